demux_channel_counter: RTL and testbench
========================================

DEMUX_CHANNEL_COUNTER -- requirements
Module: demux_channel_counter

Interface
REQ-001 SHALL have parameter CW, default 8, width of each per-channel event counter (legal 2..16).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port y_in, input, 4, one-hot channel outputs of the upstream 1-to-4 demux.
REQ-005 SHALL have port in_valid, input, 1, y_in is sampled only when high.
REQ-006 SHALL have port clr, input, 1, synchronous clear of all counters and err.
REQ-007 SHALL have port rd_req, input, 1, level readout request.
REQ-008 SHALL have port rd_ch, input, 2, channel index to read, sampled with rd_req.
REQ-009 SHALL have port rd_data, output, CW, counter value of the latched channel.
REQ-010 SHALL have port rd_valid, output, 1, rd_data is stable and valid.
REQ-011 SHALL have port err, output, 1, sticky flag: illegal (non-one-hot, non-zero) y_in seen.

Function
REQ-012 On in_valid=1 with y_in exactly one-hot, SHALL increment counter[i] for the set bit i, one cycle latency.
REQ-013 On in_valid=1 with y_in=4'b0000, SHALL change no counter (demux data bit was 0).
REQ-014 On in_valid=1 with two or more y_in bits set, SHALL change no counter and SHALL set err next cycle.
REQ-015 On in_valid=0, SHALL ignore y_in entirely.
REQ-016 Counter overflow at 2^CW-1: behaviour per REQ-026/027.
REQ-017 Readout FSM SHALL have states IDLE, CAPTURE, HOLD.
REQ-018 IDLE -> CAPTURE when rd_req=1; rd_ch latched on that edge.
REQ-019 CAPTURE -> HOLD unconditionally; on this edge rd_data loads counter[latched ch] value as of end of previous cycle, rd_valid goes 1.
REQ-020 HOLD: rd_data frozen, rd_valid=1 while rd_req=1; HOLD -> IDLE when rd_req=0, rd_valid=0 the next cycle.
REQ-021 Increment on the read channel during CAPTURE SHALL NOT appear in rd_data (pre-increment snapshot); counting never stalls during reads.
REQ-022 clr=1 SHALL zero all counters and err next edge, overriding any increment that cycle; SHALL NOT disturb the readout FSM or rd_data.
REQ-023 rd_ch changes while not in IDLE SHALL be ignored.

Reset
REQ-024 rst=1 SHALL asynchronously force all counters=0, err=0, rd_data=0, rd_valid=0, FSM=IDLE.
REQ-025 Reset asserted mid-read SHALL abort the read; after release FSM in IDLE and a held rd_req=1 starts a new read on the next edge.

Configuration
REQ-026 With macro DEMUX_CNT_SATURATE_EN defined, counters SHALL saturate at 2^CW-1 and hold.
REQ-027 Without DEMUX_CNT_SATURATE_EN, counters SHALL wrap from 2^CW-1 to 0.

Verification
REQ-028 rst, then in_valid=1, y_in=4'b0100 for 5 cycles; read ch2 -> rd_data=5, rd_valid=1 two edges after rd_req; ch0/1/3 read 0.
REQ-029 y_in=4'b0011 with in_valid=1 -> no counter change, err=1 next cycle and stays 1 until clr or rst.
REQ-030 Drive 260 pulses on ch1, CW=8 -> rd_data=4 without macro, 255 with DEMUX_CNT_SATURATE_EN.
REQ-031 ch3 at 7, rd_req with rd_ch=3 while y_in=4'b1000 pulses during CAPTURE -> rd_data=7; later read gives 8 or more.
REQ-032 rst asserted for 1 cycle during HOLD -> rd_valid, rd_data, all counters 0 immediately; rd_req held -> new read returns 0.
REQ-033 clr=1 same cycle as y_in=4'b0001 with counter[0]=3 -> counter[0]=0 after edge.

Source files
------------

// File: rtl/demux_channel_counter_if.sv
// Bus bundle for demux_channel_counter: demux event input, clear, and channel readout handshake.
interface demux_channel_counter_if #(
    parameter int unsigned CW = 8
) ();
    logic [3:0]    y_in;
    logic          in_valid;
    logic          clr;
    logic          rd_req;
    logic [1:0]    rd_ch;
    logic [CW-1:0] rd_data;
    logic          rd_valid;
    logic          err;

    modport master (
        output y_in, in_valid, clr, rd_req, rd_ch,
        input  rd_data, rd_valid, err
    );

    modport slave (
        input  y_in, in_valid, clr, rd_req, rd_ch,
        output rd_data, rd_valid, err
    );
endinterface

// File: rtl/demux_channel_counter.sv
// Per-channel event counters behind a one-hot 1-to-4 demux, with a snapshot readout FSM.
// Define DEMUX_CNT_SATURATE_EN to make counters saturate at 2^CW-1 instead of wrapping.
module demux_channel_counter #(
    parameter int unsigned CW = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    demux_channel_counter_if.slave  bus
);
    localparam int unsigned NCH = 4;
    localparam int unsigned CHW = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } rd_state_t;

    logic [CW-1:0]  r_cnt [NCH];
    logic           r_err;
    rd_state_t      r_state;
    logic [CHW-1:0] r_ch;
    logic [CW-1:0]  r_rd_data;
    logic           r_rd_valid;

    logic           w_multi;
    logic           w_onehot;
    logic [NCH-1:0] w_inc;
    logic [CW-1:0]  w_next [NCH];

    // x & (x-1) is non-zero exactly when two or more bits are set
    assign w_multi  = (bus.y_in & (bus.y_in - 4'd1)) != 4'd0;
    assign w_onehot = (bus.y_in != 4'd0) && !w_multi;
    assign w_inc    = (bus.in_valid && w_onehot) ? bus.y_in : 4'd0;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_next[i] = r_cnt[i] + CW'(1);
`ifdef DEMUX_CNT_SATURATE_EN
            if (r_cnt[i] == {CW{1'b1}}) begin
                w_next[i] = r_cnt[i];
            end
`endif
        end
    end

    // Counters and sticky error; clear wins over any increment in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
            r_err <= 1'b0;
        end else if (bus.clr) begin
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_inc[i]) begin
                    r_cnt[i] <= w_next[i];
                end
            end
            if (bus.in_valid && w_multi) begin
                r_err <= 1'b1;
            end
        end
    end

    // Readout: snapshot is taken from the register value before the CAPTURE edge's increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ch       <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rd_valid <= 1'b0;
                    if (bus.rd_req) begin
                        r_ch    <= bus.rd_ch;
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_rd_data  <= r_cnt[r_ch];
                    r_rd_valid <= 1'b1;
                    r_state    <= HOLD;
                end
                HOLD: begin
                    if (!bus.rd_req) begin
                        r_rd_valid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_rd_valid <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_demux_channel_counter.sv
// Directed self-checking bench for demux_channel_counter (CW=8); honours DEMUX_CNT_SATURATE_EN.
module tb_demux_channel_counter;
    localparam int unsigned CW = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [CW-1:0] exp_wrap;

    demux_channel_counter_if #(.CW(CW)) u_if ();

    demux_channel_counter #(.CW(CW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [3:0] y, input int n);
        u_if.in_valid = 1'b1;
        u_if.y_in     = y;
        step(n);
        u_if.in_valid = 1'b0;
        u_if.y_in     = 4'd0;
    endtask

    task automatic read_ch(input string tag, input logic [1:0] ch, input logic [CW-1:0] exp);
        u_if.rd_req = 1'b1;
        u_if.rd_ch  = ch;
        step(1);
        chk({tag, "_capture_valid"}, 32'(u_if.rd_valid), 32'd0);
        step(1);
        chk({tag, "_valid"}, 32'(u_if.rd_valid), 32'd1);
        chk({tag, "_data"}, 32'(u_if.rd_data), 32'(exp));
        u_if.rd_req = 1'b0;
        step(1);
        chk({tag, "_release"}, 32'(u_if.rd_valid), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst           = 1'b1;
        u_if.y_in     = 4'd0;
        u_if.in_valid = 1'b0;
        u_if.clr      = 1'b0;
        u_if.rd_req   = 1'b0;
        u_if.rd_ch    = 2'd0;
        step(3);
        chk("rst_rd_valid", 32'(u_if.rd_valid), 32'd0);
        chk("rst_rd_data", 32'(u_if.rd_data), 32'd0);
        chk("rst_err", 32'(u_if.err), 32'd0);
        rst = 1'b0;
        step(1);

        // Five events on channel 2, then garbage with in_valid low must be ignored
        pulse(4'b0100, 5);
        u_if.y_in = 4'b1111;
        step(2);
        u_if.y_in = 4'd0;
        chk("ignore_invalid_err", 32'(u_if.err), 32'd0);
        pulse(4'b0000, 2);
        read_ch("ch2_five", 2'd2, 8'd5);
        read_ch("ch0_zero", 2'd0, 8'd0);
        read_ch("ch1_zero", 2'd1, 8'd0);
        read_ch("ch3_zero", 2'd3, 8'd0);

        // Illegal multi-hot input: sticky error, no counting
        pulse(4'b0011, 1);
        chk("err_set", 32'(u_if.err), 32'd1);
        step(3);
        chk("err_sticky", 32'(u_if.err), 32'd1);
        read_ch("ch0_after_illegal", 2'd0, 8'd0);
        read_ch("ch1_after_illegal", 2'd1, 8'd0);
        u_if.clr = 1'b1;
        step(1);
        u_if.clr = 1'b0;
        chk("err_cleared", 32'(u_if.err), 32'd0);
        read_ch("ch2_cleared", 2'd2, 8'd0);

        // Clear beats a same-cycle increment
        pulse(4'b0001, 3);
        read_ch("ch0_three", 2'd0, 8'd3);
        u_if.clr      = 1'b1;
        u_if.in_valid = 1'b1;
        u_if.y_in     = 4'b0001;
        step(1);
        u_if.clr      = 1'b0;
        u_if.in_valid = 1'b0;
        u_if.y_in     = 4'd0;
        read_ch("ch0_clr_wins", 2'd0, 8'd0);

        // Snapshot excludes an increment during CAPTURE; rd_ch change after IDLE is ignored
        pulse(4'b1000, 7);
        u_if.rd_req = 1'b1;
        u_if.rd_ch  = 2'd3;
        step(1);
        u_if.rd_ch    = 2'd0;
        u_if.in_valid = 1'b1;
        u_if.y_in     = 4'b1000;
        step(1);
        u_if.in_valid = 1'b0;
        u_if.y_in     = 4'd0;
        chk("snap_valid", 32'(u_if.rd_valid), 32'd1);
        chk("snap_data", 32'(u_if.rd_data), 32'd7);
        u_if.clr = 1'b1;
        step(1);
        u_if.clr = 1'b0;
        chk("hold_clr_valid", 32'(u_if.rd_valid), 32'd1);
        chk("hold_clr_data", 32'(u_if.rd_data), 32'd7);
        u_if.rd_req = 1'b0;
        step(1);
        chk("snap_release", 32'(u_if.rd_valid), 32'd0);
        read_ch("ch3_after_clr", 2'd3, 8'd0);
        pulse(4'b1000, 8);
        read_ch("ch3_eight", 2'd3, 8'd8);

        // 260 events on channel 1: wraps to 4, or saturates at 255
`ifdef DEMUX_CNT_SATURATE_EN
        exp_wrap = 8'd255;
`else
        exp_wrap = 8'd4;
`endif
        pulse(4'b0010, 260);
        read_ch("ch1_overflow", 2'd1, exp_wrap);

        // Asynchronous reset in HOLD aborts the read; held rd_req starts a fresh one
        pulse(4'b0100, 2);
        u_if.rd_req = 1'b1;
        u_if.rd_ch  = 2'd2;
        step(2);
        chk("pre_rst_data", 32'(u_if.rd_data), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(u_if.rd_valid), 32'd0);
        chk("async_rst_data", 32'(u_if.rd_data), 32'd0);
        step(1);
        rst = 1'b0;
        step(1);
        chk("rerun_capture_valid", 32'(u_if.rd_valid), 32'd0);
        step(1);
        chk("rerun_valid", 32'(u_if.rd_valid), 32'd1);
        chk("rerun_data", 32'(u_if.rd_data), 32'd0);
        u_if.rd_req = 1'b0;
        step(1);
        read_ch("ch1_after_rst", 2'd1, 8'd0);
        read_ch("ch3_after_rst", 2'd3, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
